// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
//
// Write-side pointer and flag controller for an asynchronous FIFO. Everything
// here runs in the write clock domain. The block owns the binary and Gray
// write pointers, drives the dual-port RAM write strobe and address, and
// produces the full / almost-full / fill-level / sticky-overflow status.
//
// Parameters
//   ADDR_WIDTH    RAM address width; depth = 2**ADDR_WIDTH, pointers are
//                 ADDR_WIDTH+1 bits wide.
//   AFULL_THRESH  almost_full asserts when the fill level is >= this value
//                 (legal range 1..2**ADDR_WIDTH).
//
// Ports
//   clk          write-domain clock
//   rst_n        synchronous active-low reset
//   wr_en        write request from the producer
//   ovf_clr      clears the sticky overflow flag
//   wq2_rptr     Gray read pointer, already synchronized into this domain
//   mem_we       RAM write enable (combinational)
//   mem_waddr    RAM write address (low bits of the binary write pointer)
//   wptr         registered Gray write pointer, toward the read domain
//   full         registered full flag
//   almost_full  registered almost-full flag
//   wr_level     registered fill level, 0..2**ADDR_WIDTH
//   overflow     sticky flag: a write was attempted while full
// -----------------------------------------------------------------------------
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH   = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  ovf_clr,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow
);

    localparam int PW = ADDR_WIDTH + 1;

    // Inverting the two MSBs of the read pointer yields the Gray code of the
    // read pointer plus one full FIFO depth.
    localparam logic [PW-1:0] FULL_MASK  = PW'(3) << (ADDR_WIDTH - 1);
    localparam logic [PW-1:0] AFULL_LVL  = PW'(AFULL_THRESH);

    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_wptr;
    logic          r_full;
    logic          r_almost_full;
    logic [PW-1:0] r_wr_level;
    logic          r_overflow;

    logic          w_accept;
    logic [PW-1:0] w_wbin_next;
    logic [PW-1:0] w_wgray_next;
    logic [PW-1:0] w_rbin;
    logic [PW-1:0] w_level_next;
    logic          w_full_next;

    // The strobe is gated by reset so no RAM write can happen while the
    // pointers are being cleared.
    assign w_accept     = wr_en & ~r_full & rst_n;
    assign w_wbin_next  = r_wbin + PW'(w_accept);
    assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);
    assign w_full_next  = (w_wgray_next == (wq2_rptr ^ FULL_MASK));

    // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
    always_comb begin
        w_rbin = '0;
        for (int i = 0; i < PW; i++) begin
            w_rbin[i] = ^(wq2_rptr >> i);
        end
    end

    assign w_level_next = w_wbin_next - w_rbin;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wbin        <= '0;
            r_wptr        <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_wr_level    <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_wbin        <= w_wbin_next;
            r_wptr        <= w_wgray_next;
            r_full        <= w_full_next;
            r_almost_full <= (w_level_next >= AFULL_LVL);
            r_wr_level    <= w_level_next;
            // A rejected write sets the flag even if a clear arrives together.
            r_overflow    <= (wr_en & r_full) | (r_overflow & ~ovf_clr);
        end
    end

    assign mem_we      = w_accept;
    assign mem_waddr   = r_wbin[ADDR_WIDTH-1:0];
    assign wptr        = r_wptr;
    assign full        = r_full;
    assign almost_full = r_almost_full;
    assign wr_level    = r_wr_level;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_ctrl
//
// Self-checking bench for fifo_wr_ctrl (ADDR_WIDTH=3, AFULL_THRESH=6). A
// behavioural model tracks the number of words written and the read count as
// plain integers; flags and level follow from their difference.
// -----------------------------------------------------------------------------
module tb_fifo_wr_ctrl;

    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
    localparam int PMOD  = 2 * DEPTH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic          ovf_clr;
    logic [AW:0]   wq2_rptr;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [AW:0]   wptr;
    logic          full;
    logic          almost_full;
    logic [AW:0]   wr_level;
    logic          overflow;

    fifo_wr_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .ovf_clr     (ovf_clr),
        .wq2_rptr    (wq2_rptr),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .wptr        (wptr),
        .full        (full),
        .almost_full (almost_full),
        .wr_level    (wr_level),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: words written (mod 16), words read (mod 16), flags.
    int m_w    = 0;
    int m_rb   = 0;
    int m_lvl  = 0;
    bit m_full = 0;
    bit m_af   = 0;
    bit m_ovf  = 0;
    bit m_valid = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [AW:0] to_gray(input int b);
        logic [AW:0] v;
        v = b[AW:0];
        return v ^ (v >> 1);
    endfunction

    // One clock: apply inputs at the negedge, check DUT against the model,
    // then advance the model across the posedge.
    task automatic cyc(input bit rn, input bit we, input bit clr, input int rb);
        bit acc;
        rst_n    = rn;
        wr_en    = we;
        ovf_clr  = clr;
        m_rb     = rb % PMOD;
        wq2_rptr = to_gray(m_rb);
        #1;
        acc = rn && we && !m_full;
        check("mem_we", mem_we, acc);
        if (m_valid) begin
            if (acc) check("mem_waddr", mem_waddr, m_w % DEPTH);
            check("wptr", wptr, to_gray(m_w));
            check("full", full, m_full);
            check("almost_full", almost_full, m_af);
            check("wr_level", wr_level, m_lvl);
            check("overflow", overflow, m_ovf);
        end
        @(posedge clk);
        if (!rn) begin
            m_w = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0;
            m_valid = 1;
        end else begin
            m_ovf  = (we && m_full) || (m_ovf && !clr);
            m_w    = (m_w + int'(acc)) % PMOD;
            m_lvl  = (m_w - m_rb + PMOD) % PMOD;
            m_full = (m_lvl == DEPTH);
            m_af   = (m_lvl >= 6);
        end
        @(negedge clk);
    endtask

    logic [AW:0] gtab [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                              4'b0111, 4'b0101, 4'b0100, 4'b1100};

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; ovf_clr = 1'b0; wq2_rptr = '0;
        @(negedge clk);

        // Reset with writes requested.
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
        check("rst_wptr", wptr, 0);
        check("rst_level", wr_level, 0);
        check("rst_flags", {full, almost_full, overflow}, 0);

        // Fill from empty.
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 0, 0);
            check("fill_wptr", wptr, gtab[i]);
            check("fill_af", almost_full, (i >= 5));
        end
        check("fill_full", full, 1);
        check("fill_level", wr_level, 8);

        // Overflow set, set-wins-over-clear, then clear.
        cyc(1, 1, 0, 0);
        check("ovf_wptr", wptr, 4'b1100);
        check("ovf_set", overflow, 1);
        cyc(1, 1, 1, 0);
        check("ovf_setwins", overflow, 1);
        cyc(1, 0, 1, 0);
        check("ovf_clr", overflow, 0);

        // Drain one and refill.
        cyc(1, 0, 0, 1);
        check("drain_full", full, 0);
        check("drain_level", wr_level, 7);
        check("drain_af", almost_full, 1);
        check("refill_addr", mem_waddr, 0);
        cyc(1, 1, 0, 1);
        check("refill_wptr", wptr, 4'b1101);
        check("refill_full", full, 1);

        // Wrap-around with the reader keeping pace.
        cyc(1, 0, 0, 2);
        for (int i = 0; i < 16; i++) begin
            cyc(1, 1, 0, m_rb + 1);
            check("wrap_nofull", full, 0);
        end

        // Mid-operation reset at level 5.
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0);
        check("mid_level", wr_level, 5);
        cyc(0, 1, 0, 0);
        check("mid_rst", {wptr, wr_level, full, almost_full, overflow}, 0);
        cyc(1, 1, 0, 0);
        check("mid_resume", wptr, 4'b0001);

        // Randomized traffic with a legal, one-step-at-a-time read pointer.
        for (int i = 0; i < 3000; i++) begin
            int rb;
            rb = m_rb;
            if ($urandom_range(0, 299) == 0) begin
                cyc(0, $urandom_range(0, 1) == 1, 0, 0);
            end else begin
                if (((m_w - m_rb + PMOD) % PMOD) > 0 && $urandom_range(0, 2) == 0)
                    rb = m_rb + 1;
                cyc(1, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rb);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-side pointer and flag controller for the asynchronous FIFO, running entirely in the write clock domain. It owns the binary and Gray write pointers and generates the dual-port RAM write enable and address. It also computes full, almost_full, fill level and a sticky overflow flag. Its inputs come from the read pointer after the two-flop synchronizer. Its Gray pointer output feeds the synchronizer toward the read domain.

Parameters:
ADDR_WIDTH, 3, RAM address width; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
AFULL_THRESH, 6, almost_full asserts when fill level >= this value; legal range 1..2**ADDR_WIDTH.

Ports:
clk  input  1  write-domain clock.
rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
wr_en  input  1  write request from producer.
ovf_clr  input  1  clears the sticky overflow flag.
wq2_rptr  input  ADDR_WIDTH+1  Gray read pointer, already synchronized into this domain.
mem_we  output  1  RAM write enable (combinational).
mem_waddr  output  ADDR_WIDTH  RAM write address (= wbin[ADDR_WIDTH-1:0]).
wptr  output  ADDR_WIDTH+1  registered Gray write pointer, to be synchronized into the read domain.
full  output  1  registered full flag.
almost_full  output  1  registered almost-full flag.
wr_level  output  ADDR_WIDTH+1  registered fill level, 0..2**ADDR_WIDTH.
overflow  output  1  sticky flag: a write was attempted while full.

Behaviour:
- Single clock domain (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at posedge):
  - wbin, wptr, full, almost_full, wr_level and overflow all clear to 0.
  - Applies mid-operation; the remote-side wq2_rptr is not the responsibility of this block.
- Accept condition: accept = wr_en & ~full.
  - mem_we = accept (combinational, same cycle).
  - mem_waddr = current wbin low bits; data is written at this address on the accepting edge.
- Pointer update:
  - wbin_next = wbin + accept, modulo 2**(ADDR_WIDTH+1).
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - wbin and wptr register wbin_next and wgray_next every cycle.
  - Wrap from all-ones to zero is natural modulo arithmetic.
- Full flag:
  - full <= (wgray_next == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]}).
  - Recomputed every cycle, with or without a write.
  - Asserts on the same edge that accepts the last free slot.
  - Deasserts one clk after wq2_rptr changes; the synchronizer adds its own latency, which is acceptable pessimism.
- Level:
  - rbin = Gray-to-binary of wq2_rptr (combinational; bit i = XOR of bits MSB..i).
  - wr_level <= (wbin_next - rbin) mod 2**(ADDR_WIDTH+1).
- Almost-full: almost_full <= (level_next >= AFULL_THRESH), using the same level_next as wr_level.
- Overflow:
  - Set when wr_en & full.
  - Cleared by ovf_clr; set wins over a simultaneous clear.
  - Held otherwise.
- A write attempted while full:
  - mem_we stays 0 and the pointers are unchanged.
  - No other side effect besides overflow.
- wq2_rptr is treated as a valid Gray code at all times (single-bit changes only); no checking is performed.

Test Plan:
All scenarios use ADDR_WIDTH=3 and AFULL_THRESH=6 (depth 8, 4-bit pointers).
1. Reset: hold rst_n=0 with wr_en=1 for 3 cycles -> mem_we=0 during reset; after release, wptr=0000, wr_level=0, and full, almost_full and overflow are all 0.
2. Fill from empty: wq2_rptr=0000 and 8 back-to-back wr_en cycles.
   - wptr steps 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100.
   - mem_waddr steps 0..7.
   - almost_full=1 after the 6th accept (wr_level=6).
   - full=1 after the 8th accept (wr_level=8).
3. Overflow: with the FIFO full, drive wr_en=1 for 1 cycle -> mem_we=0, wptr stays 1100, overflow=1.
   - Assert ovf_clr=1 together with another wr_en -> overflow stays 1.
   - ovf_clr alone -> overflow=0.
4. Drain and refill: full, then wq2_rptr goes 0000→0001 with wr_en=0 -> next cycle full=0, wr_level=7, almost_full=1.
   - One write -> mem_waddr=0 and wptr=1101 (bin 9).
   - full=1 again on that edge.
5. Wrap-around: step wq2_rptr alongside writes so the FIFO never fills; write 16 times -> wbin goes 15→0, wptr goes 1000→0000, and no spurious full occurs.
6. Mid-operation reset: wr_level=5 with wr_en=1, then rst_n=0 for one cycle -> on that edge all outputs clear; normal accept resumes the cycle after release.
